// File: rtl/matrix_write_scheduler_if.sv
// Write-scheduler bus: per-lane element offers in, granted write port out.
interface matrix_write_scheduler_if #(
  parameter int unsigned NUM_REQ          = 4,
  parameter int unsigned MAX_ELEMENT_SIZE = 8,
  parameter int unsigned MAX_SIZE_A       = 32,
  parameter int unsigned MAX_SIZE_B       = 32
);
  localparam int unsigned AW = $clog2(MAX_SIZE_A);
  localparam int unsigned BW = $clog2(MAX_SIZE_B);

  logic [NUM_REQ-1:0]                  req_valid;
  logic [NUM_REQ*AW-1:0]               req_row;
  logic [NUM_REQ*BW-1:0]               req_col;
  logic [NUM_REQ*MAX_ELEMENT_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]                  req_ready;

  logic                                valid_data_in;
  logic [AW-1:0]                       row_addr;
  logic [BW-1:0]                       col_addr;
  logic [MAX_ELEMENT_SIZE-1:0]         matrix_element;

  // Compute lanes plus compiler-side observer.
  modport master (
    output req_valid, req_row, req_col, req_data,
    input  req_ready, valid_data_in, row_addr, col_addr, matrix_element
  );

  // The scheduler itself.
  modport slave (
    input  req_valid, req_row, req_col, req_data,
    output req_ready, valid_data_in, row_addr, col_addr, matrix_element
  );
endinterface

// File: rtl/matrix_write_scheduler.sv
// Round-robin arbiter sharing the compiler's single result-write port between compute lanes.
// Tracks written addresses in a bitmap, signals matrix completion, then holds all lanes off
// until the compiler reports it is free again (rising edge of frame_free).
module matrix_write_scheduler #(
  parameter int unsigned  NUM_REQ          = 4,
  parameter int unsigned  MAX_ELEMENT_SIZE = 8,
  parameter int unsigned  MAX_SIZE_A       = 32,
  parameter int unsigned  MAX_SIZE_B       = 32,
  localparam int unsigned N                = MAX_SIZE_A * MAX_SIZE_B,
  localparam int unsigned CW               = $clog2(N) + 1
) (
  input  logic                           inter_refclk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           frame_free,
  matrix_write_scheduler_if.slave        bus,
  output logic                           busy,
  output logic                           matrix_done,
  output logic                           dup_error,
  output logic [CW-1:0]                  elem_count
);
  localparam int unsigned AW = $clog2(MAX_SIZE_A);
  localparam int unsigned BW = $clog2(MAX_SIZE_B);
  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam int unsigned EW = MAX_ELEMENT_SIZE;

  typedef enum logic [1:0] {StIdle, StCollect, StHold} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   last_grant_q, last_grant_d;
  logic [N-1:0]    bitmap_q, bitmap_d;
  logic [CW-1:0]   count_q, count_d;
  logic            frame_free_q;
  logic            valid_q, valid_d;
  logic [AW-1:0]   row_q, row_d;
  logic [BW-1:0]   col_q, col_d;
  logic [EW-1:0]   elem_q, elem_d;
  logic            done_q, done_d;
  logic            dup_q, dup_d;

  logic [NUM_REQ-1:0] grant;
  logic [GW-1:0]      grant_idx;
  logic               grant_found;
  int unsigned        cand;
  logic [AW-1:0]      sel_row;
  logic [BW-1:0]      sel_col;
  logic [EW-1:0]      sel_data;
  logic [AW+BW-1:0]   addr;

  // Round-robin search starting one past the last granted lane; only while collecting.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    cand        = 0;
    if (state_q == StCollect) begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        cand = 32'(last_grant_q) + k;
        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
        if (!grant_found && bus.req_valid[GW'(cand)]) begin
          grant_found = 1'b1;
          grant_idx   = GW'(cand);
        end
      end
    end
    if (grant_found) grant[grant_idx] = 1'b1;
  end

  // Select the granted lane's address and element.
  always_comb begin
    sel_row  = '0;
    sel_col  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_row  = bus.req_row[i*AW +: AW];
        sel_col  = bus.req_col[i*BW +: BW];
        sel_data = bus.req_data[i*EW +: EW];
      end
    end
  end

  // Power-of-2 dimensions make row*MAX_SIZE_B + col a plain concatenation.
  assign addr = {sel_row, sel_col};

  // Next-state: FSM transitions, bitmap/count bookkeeping and registered write port.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    bitmap_d     = bitmap_q;
    count_d      = count_q;
    valid_d      = 1'b0;
    row_d        = row_q;
    col_d        = col_q;
    elem_d       = elem_q;
    done_d       = 1'b0;
    dup_d        = 1'b0;
    case (state_q)
      StIdle: begin
        if (start && frame_free) begin
          state_d  = StCollect;
          bitmap_d = '0;
          count_d  = '0;
        end
      end
      StCollect: begin
        if (grant_found) begin
          last_grant_d = grant_idx;
          valid_d      = 1'b1;
          row_d        = sel_row;
          col_d        = sel_col;
          elem_d       = sel_data;
          if (bitmap_q[addr]) begin
            // Overwrite is forwarded but not counted.
            dup_d = 1'b1;
          end else begin
            bitmap_d[addr] = 1'b1;
            if (count_q != CW'(N)) count_d = count_q + CW'(1);
            if (count_q == CW'(N - 1)) begin
              done_d  = 1'b1;
              state_d = StHold;
            end
          end
        end
      end
      StHold: begin
        if (frame_free && !frame_free_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge inter_refclk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= GW'(NUM_REQ - 1);
      bitmap_q     <= '0;
      count_q      <= '0;
      frame_free_q <= 1'b0;
      valid_q      <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      elem_q       <= '0;
      done_q       <= 1'b0;
      dup_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      bitmap_q     <= bitmap_d;
      count_q      <= count_d;
      frame_free_q <= frame_free;
      valid_q      <= valid_d;
      row_q        <= row_d;
      col_q        <= col_d;
      elem_q       <= elem_d;
      done_q       <= done_d;
      dup_q        <= dup_d;
    end
  end

  assign bus.req_ready      = grant;
  assign bus.valid_data_in  = valid_q;
  assign bus.row_addr       = row_q;
  assign bus.col_addr       = col_q;
  assign bus.matrix_element = elem_q;
  assign busy               = (state_q != StIdle);
  assign matrix_done        = done_q;
  assign dup_error          = dup_q;
  assign elem_count         = count_q;
endmodule
